sobel3x3_det: RTL and testbench



---
 rtl/sobel3x3_det.sv | 87 ++++++++
 tb/tb_sobel3x3_det.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/sobel3x3_det.sv
// Purpose : 3x3 Sobel edge magnitude |Gx|+|Gy| on 8-bit grey pixels, saturated to PIX_W bits.
// Latency : 1 cycle (combinational datapath into the z_out register), one window per clock.
// Backpressure: none; every rising edge of clk samples z1..z9.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-low; forces z_out to 0 immediately
//   z1..z3   window row above the centre (left, centre, right)
//   z4..z6   centre row (z5 is the centre pixel and does not contribute)
//   z7..z9   window row below the centre (left, centre, right)
//   z_out    registered edge value
//
// Optional feature: define SOBEL_THRESHOLD_EN to binarise the output
// (z_out = 0xFF when the saturated magnitude >= THRESHOLD, else 0x00).
module sobel3x3_det #(
  parameter int PIX_W     = 8,
  parameter int THRESHOLD = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] z1,
  input  logic [PIX_W-1:0] z2,
  input  logic [PIX_W-1:0] z3,
  input  logic [PIX_W-1:0] z4,
  input  logic [PIX_W-1:0] z5,
  input  logic [PIX_W-1:0] z6,
  input  logic [PIX_W-1:0] z7,
  input  logic [PIX_W-1:0] z8,
  input  logic [PIX_W-1:0] z9,
  output logic [PIX_W-1:0] z_out
);

  // Three extra bits hold a weighted sum of four pixels (max 4*255) plus sign,
  // and also the unsigned sum of the two absolute values (max 2040).
  localparam int SW = PIX_W + 3;
  localparam logic [SW-1:0] MAX_MAG = {3'b000, {PIX_W{1'b1}}};

  logic [SW-1:0]        pos_x, neg_x, pos_y, neg_y;
  logic signed [SW-1:0] gx, gy;
  logic [SW-1:0]        abs_x, abs_y, mag;
  logic [PIX_W-1:0]     sat_mag;
  logic [PIX_W-1:0]     z_out_d, z_out_q;

  // The centre pixel has zero weight in both kernels.
  logic unused_z5;
  assign unused_z5 = ^z5;

  always_comb begin
    pos_x = {3'b000, z3} + {2'b00, z6, 1'b0} + {3'b000, z9};
    neg_x = {3'b000, z1} + {2'b00, z4, 1'b0} + {3'b000, z7};
    pos_y = {3'b000, z7} + {2'b00, z8, 1'b0} + {3'b000, z9};
    neg_y = {3'b000, z1} + {2'b00, z2, 1'b0} + {3'b000, z3};

    gx = signed'(pos_x - neg_x);
    gy = signed'(pos_y - neg_y);

    // Magnitudes never exceed 1020, so negation cannot overflow SW bits.
    abs_x = gx[SW-1] ? unsigned'(-gx) : unsigned'(gx);
    abs_y = gy[SW-1] ? unsigned'(-gy) : unsigned'(gy);
    mag   = abs_x + abs_y;

    // Clamp rather than wrap: strong edges must read as full scale.
    sat_mag = (mag > MAX_MAG) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];

`ifdef SOBEL_THRESHOLD_EN
    z_out_d = (sat_mag >= PIX_W'(THRESHOLD)) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
`else
    z_out_d = sat_mag;
`endif
  end

`ifndef SOBEL_THRESHOLD_EN
  // THRESHOLD only matters in the binarised build.
  localparam int unused_threshold = THRESHOLD;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      z_out_q <= '0;
    end else begin
      z_out_q <= z_out_d;
    end
  end

  assign z_out = z_out_q;

endmodule

// File: tb/tb_sobel3x3_det.sv
// Purpose : self-checking bench for sobel3x3_det (default build, saturated magnitude).
// Latency : expects z_out one clock after the window is presented.
// Backpressure: none; a new window is driven every cycle.
module tb_sobel3x3_det;

  typedef logic [7:0] win_t [9];

  logic       clk = 1'b0;
  logic       reset;
  win_t       cur;
  logic [7:0] z_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sobel3x3_det #(
    .PIX_W    (8),
    .THRESHOLD(128)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .z1   (cur[0]),
    .z2   (cur[1]),
    .z3   (cur[2]),
    .z4   (cur[3]),
    .z5   (cur[4]),
    .z6   (cur[5]),
    .z7   (cur[6]),
    .z8   (cur[7]),
    .z9   (cur[8]),
    .z_out(z_out)
  );

  // Reference: convolve the window with the two Sobel kernels, add the
  // absolute responses, clamp to 255.
  function automatic logic [7:0] ref_edge(input win_t w);
    int kx [9];
    int ky [9];
    int sx, sy, m;
    kx = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    ky = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    sx = 0;
    sy = 0;
    for (int i = 0; i < 9; i++) begin
      sx += kx[i] * int'(w[i]);
      sy += ky[i] * int'(w[i]);
    end
    m = (sx < 0 ? -sx : sx) + (sy < 0 ? -sy : sy);
    if (m > 255) m = 255;
    return 8'(m);
  endfunction

  task automatic check(input string tag, input logic [7:0] exp);
    checks++;
    assert (z_out === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, z_out, exp);
    end
  endtask

  task automatic set_all(input logic [7:0] v);
    for (int i = 0; i < 9; i++) cur[i] = v;
  endtask

  task automatic vert_edge(input logic [7:0] v);
    set_all(8'd0);
    cur[2] = v;
    cur[5] = v;
    cur[8] = v;
  endtask

  // Let one rising edge sample the current window, then check just after it.
  task automatic step(input string tag, input logic [7:0] exp);
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    // Reset held with a saturating window present.
    reset = 1'b0;
    vert_edge(8'd255);
    #1;
    check("rst_async", 8'd0);
    repeat (3) step("rst_hold", 8'd0);

    // Release between edges; first edge with reset high produces the result.
    reset = 1'b1;
    step("rst_release", 8'd255);

    set_all(8'd0);
    cur[0] = 8'd1;
    step("single_pixel", 8'd2);

    set_all(8'h80);
    step("flat_field", 8'd0);
    cur[4] = 8'hFF;
    step("flat_centre", 8'd0);

    vert_edge(8'd255);
    step("vert_saturate", 8'd255);

    vert_edge(8'd10);
    step("grad_x", 8'd40);

    set_all(8'd0);
    cur[6] = 8'd10;
    cur[7] = 8'd10;
    cur[8] = 8'd10;
    step("grad_y", 8'd40);

    // Input change between edges must not reach z_out before the next edge.
    set_all(8'd0);
    cur[0] = 8'd1;
    #2;
    check("hold_between", 8'd40);
    step("single_again", 8'd2);

    // Reset mid-cycle with a saturating window pending.
    vert_edge(8'd255);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_async", 8'd0);
    @(posedge clk);
    #1;
    check("rst_mid_hold", 8'd0);
    vert_edge(8'd10);
    reset = 1'b1;
    step("rst_no_stale", 8'd40);

    // Random windows; half drawn from a small range to exercise the unsaturated region.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 9; i++) begin
        cur[i] = (n % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 30));
      end
      step("random", ref_edge(cur));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
